volume_level_meter: RTL and testbench

VOLUME_LEVEL_METER -- requirements
Module: volume_level_meter

---
 rtl/volume_level_pkg.sv | 25 ++
 rtl/level_quantizer.sv | 21 ++
 rtl/volume_level_meter.sv | 116 +++++++++++
 tb/tb_volume_level_meter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/volume_level_pkg.sv
// Shared constants and types for the volume level meter.
// Thresholds map an 11-bit magnitude (0..2047, distance from midscale)
// onto a 0..5 display level.
package volume_level_pkg;

  // Display level, 0..LEVEL_MAX; codes 6 and 7 are never produced.
  typedef logic [2:0] level_t;

  // Magnitude width: |sample - midscale| of a 12-bit code fits in 11 bits.
  localparam int unsigned MagW = 11;

  // ADC code for silence.
  localparam logic [11:0] MIDSCALE = 12'd2048;

  // Quantization thresholds, strictly increasing.
  localparam logic [10:0] TH1 = 11'd128;
  localparam logic [10:0] TH2 = 11'd384;
  localparam logic [10:0] TH3 = 11'd768;
  localparam logic [10:0] TH4 = 11'd1280;
  localparam logic [10:0] TH5 = 11'd1792;

  // Highest level the quantizer can report.
  localparam level_t LEVEL_MAX = 3'd5;

endpackage

// File: rtl/level_quantizer.sv
// Combinational magnitude-to-level quantizer.
// Output is the number of thresholds TH1..TH5 that are <= the magnitude,
// so the result is always 0..5.
module level_quantizer
  import volume_level_pkg::*;
(
  input  logic [MagW-1:0] i_mag,
  output level_t          o_level
);

  // Count the thresholds passed; strictly increasing thresholds keep this monotonic.
  always_comb begin
    o_level = '0;
    if (i_mag >= TH1) o_level = o_level + 3'd1;
    if (i_mag >= TH2) o_level = o_level + 3'd1;
    if (i_mag >= TH3) o_level = o_level + 3'd1;
    if (i_mag >= TH4) o_level = o_level + 3'd1;
    if (i_mag >= TH5) o_level = o_level + 3'd1;
  end

endmodule

// File: rtl/volume_level_meter.sv
// Volume level meter: tracks the peak distance from midscale of the mic
// samples in each window of WINDOW_SAMPLES accepted samples, then publishes
// the raw peak and a quantized 0..5 level with a one-cycle level_valid pulse.
//
// Timing: the edge that accepts the last sample of a window captures the
// window peak into r_eval and restarts the window; the next edge updates
// level/peak and raises level_valid. Samples keep flowing during that
// evaluation cycle and count toward the new window, so nothing is dropped.
//
// Build option: define VOLUME_PEAK_HOLD_EN to let the displayed level rise
// immediately but fall by at most one step per window. peak always reports
// the raw window peak.
//
// Only SAMPLE_W = 12 is supported.
module volume_level_meter
  import volume_level_pkg::*;
#(
  parameter int unsigned WINDOW_SAMPLES = 4000,
  parameter int unsigned SAMPLE_W       = 12
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output level_t              level,
  output logic                level_valid,
  output logic [MagW-1:0]     peak
);

  // Counter value at which the accepted sample closes the window.
  localparam logic [15:0] LastIdx = 16'(WINDOW_SAMPLES - 1);

  // Window accumulation state.
  logic [15:0]     r_count;
  logic [MagW-1:0] r_peak_run;

  // Evaluation state: captured window peak and the pending-update flag.
  logic [MagW-1:0] r_eval;
  logic            r_eval_pend;

  // Published outputs.
  level_t          r_level;
  logic [MagW-1:0] r_peak;
  logic            r_level_valid;

  logic            w_upper;
  logic [MagW-1:0] w_mag;
  logic [MagW-1:0] w_run_max;
  logic            w_last;
  level_t          w_raw_level;
  level_t          w_level_next;

  // Magnitude from midscale. Below midscale, 2047 - sample is the bitwise
  // inverse of the low 11 bits, so no subtractor is needed on either side.
  assign w_upper   = (sample >= MIDSCALE);
  assign w_mag     = w_upper ? sample[MagW-1:0] : ~sample[MagW-1:0];

  assign w_run_max = (w_mag > r_peak_run) ? w_mag : r_peak_run;
  assign w_last    = sample_valid && (r_count == LastIdx);

  level_quantizer u_level_quantizer (
    .i_mag   (r_eval),
    .o_level (w_raw_level)
  );

`ifdef VOLUME_PEAK_HOLD_EN
  // Rise at once, decay one step per window. raw < current implies
  // current >= 1, so the decrement cannot wrap.
  assign w_level_next = (w_raw_level >= r_level) ? w_raw_level : (r_level - 3'd1);
`else
  assign w_level_next = w_raw_level;
`endif

  // Window accumulator: running peak and sample count, closed on the last sample.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_count     <= '0;
      r_peak_run  <= '0;
      r_eval      <= '0;
      r_eval_pend <= 1'b0;
    end else begin
      r_eval_pend <= 1'b0;
      if (sample_valid) begin
        if (w_last) begin
          r_eval      <= w_run_max;
          r_peak_run  <= '0;
          r_count     <= '0;
          r_eval_pend <= 1'b1;
        end else begin
          r_peak_run  <= w_run_max;
          r_count     <= r_count + 16'd1;
        end
      end
    end
  end

  // Output update: one cycle after a window closes, publish level/peak and pulse valid.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_level       <= '0;
      r_peak        <= '0;
      r_level_valid <= 1'b0;
    end else begin
      r_level_valid <= r_eval_pend;
      if (r_eval_pend) begin
        r_level <= w_level_next;
        r_peak  <= r_eval;
      end
    end
  end

  assign level       = r_level;
  assign peak        = r_peak;
  assign level_valid = r_level_valid;

endmodule

// File: tb/tb_volume_level_meter.sv
// Directed self-checking bench for volume_level_meter with WINDOW_SAMPLES=8.
// A reference model in the stimulus tasks pushes the expected level, peak
// and pulse cycle of each completed window; a negedge monitor pops and
// compares on every level_valid pulse.
module tb_volume_level_meter;

  localparam int WIN = 8;

  logic        CLOCK;
  logic        RESET;
  logic        sample_valid;
  logic [11:0] sample;
  logic [2:0]  level;
  logic        level_valid;
  logic [10:0] peak;

  volume_level_meter #(
    .WINDOW_SAMPLES (WIN),
    .SAMPLE_W       (12)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .level_valid  (level_valid),
    .peak         (peak)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int lvl;
    int pk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_pulses = 0;
  bit   mon_en = 1'b0;

  // Reference model state.
  int   m_cnt = 0;
  int   m_peak = 0;
  int   m_level = 0;
  int   m_out_peak = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int mag_of(input int s);
    return (s >= 2048) ? (s - 2048) : (2047 - s);
  endfunction

  function automatic int quant(input int m);
    int q;
    q = 0;
    if (m >= 128)  q++;
    if (m >= 384)  q++;
    if (m >= 768)  q++;
    if (m >= 1280) q++;
    if (m >= 1792) q++;
    return q;
  endfunction

  // Drive one cycle; on an accepted sample, advance the model and queue results.
  task automatic send(input bit v, input int s);
    int m;
    int raw;
    int nl;
    sample_valid = v;
    sample       = 12'(s);
    if (v) begin
      m = mag_of(s);
      if (m > m_peak) m_peak = m;
      m_cnt++;
      if (m_cnt == WIN) begin
        raw = quant(m_peak);
`ifdef VOLUME_PEAK_HOLD_EN
        nl = (raw >= m_level) ? raw : m_level - 1;
`else
        nl = raw;
`endif
        m_level    = nl;
        m_out_peak = m_peak;
        sb.push_back('{lvl: nl, pk: m_peak, cyc: cyc + 2});
        m_cnt  = 0;
        m_peak = 0;
      end
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0);
  endtask

  // One-cycle reset with a valid sample presented, which must be ignored.
  task automatic do_reset();
    RESET        = 1'b1;
    sample_valid = 1'b1;
    sample       = 12'd4095;
    sb.delete();
    m_cnt      = 0;
    m_peak     = 0;
    m_level    = 0;
    m_out_peak = 0;
    @(posedge CLOCK);
    #1;
    RESET        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_level"}, int'(level), m_level);
    chk({tag, "_peak"}, int'(peak), m_out_peak);
  endtask

  // Scoreboard monitor: every pulse must match the next queued window.
  always @(negedge CLOCK) begin
    if (mon_en && level_valid !== 1'b0) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_level", int'(level), e.lvl);
        chk("pulse_peak", int'(peak), e.pk);
      end
    end
  end

  int p0;
  int bnd_s[5]  = '{2432, 2431, 1663, 4095, 0};
  int bnd_pk[5] = '{384, 383, 384, 2047, 2047};
  int bnd_lv[5] = '{2, 1, 2, 5, 5};

  initial begin
    RESET        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Reset state and quiet period.
    chk("rst_level", int'(level), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_valid", int'(level_valid), 0);
    idle(100);
    chk_outputs("idle");

    // Silence window.
    p0 = n_pulses;
    for (int i = 0; i < WIN; i++) send(1'b1, 2048);
    idle(4);
    chk("silence_pulses", n_pulses - p0, 1);
    chk_outputs("silence");

    // Threshold and full-scale boundaries, max sample mid-window.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) send(1'b1, 2048);
      send(1'b1, bnd_s[k]);
      for (int i = 0; i < 4; i++) send(1'b1, 2048);
      idle(3);
      chk("bnd_peak", int'(peak), bnd_pk[k]);
      chk("bnd_level", int'(level), bnd_lv[k]);
    end

    // Continuous stream: four back-to-back windows, no stall.
    p0 = n_pulses;
    for (int i = 0; i < 4 * WIN; i++) send(1'b1, 4095);
    idle(4);
    chk("stream_pulses", n_pulses - p0, 4);
    chk("stream_level", int'(level), 5);

    // Decay after a loud window.
    for (int i = 0; i < WIN; i++) send(1'b1, 4095);
    idle(2);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < WIN; i++) send(1'b1, 2048);
      idle(2);
    end
`ifdef VOLUME_PEAK_HOLD_EN
    chk("decay_level", int'(level), 1);
`else
    chk("decay_level", int'(level), 0);
`endif
    chk("decay_peak", int'(peak), 0);

    // Partial window discarded by reset.
    for (int i = 0; i < 5; i++) send(1'b1, 4095);
    do_reset();
    p0 = n_pulses;
    for (int i = 0; i < WIN; i++) send(1'b1, 2048);
    idle(4);
    chk("rst_partial_pulses", n_pulses - p0, 1);
    chk_outputs("rst_partial");

    // Reset during the evaluation cycle suppresses the pulse.
    p0 = n_pulses;
    for (int i = 0; i < WIN; i++) send(1'b1, 4095);
    do_reset();
    idle(4);
    chk("rst_eval_pulses", n_pulses - p0, 0);
    chk_outputs("rst_eval");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
